// File: rtl/pito_apb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pito_apb_arbiter: round-robin share of one APB master among pito harts,  |
// | with a per-transfer ACCESS-phase watchdog.            Revision: 1.0      |
// +--------------------------------------------------------------------------+
module pito_apb_arbiter #(
  parameter int NUM_HARTS      = 8,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_HARTS-1:0]            req_valid,
  input  logic [NUM_HARTS-1:0]            req_write,
  input  logic [NUM_HARTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_HARTS*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_HARTS-1:0]            req_ready,
  output logic [NUM_HARTS-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]           resp_rdata,
  output logic                            resp_err,
  output logic [ADDR_WIDTH-1:0]           paddr,
  output logic                            psel,
  output logic                            penable,
  output logic                            pwrite,
  output logic [DATA_WIDTH-1:0]           pwdata,
  input  logic [DATA_WIDTH-1:0]           prdata,
  input  logic                            pready,
  input  logic                            pslverr
);

  localparam int c_hart_w = $clog2(NUM_HARTS);
  localparam int c_cnt_w  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_cnt_w-1:0]   c_limit = c_cnt_w'(TIMEOUT_CYCLES);
  localparam logic [c_hart_w-1:0]  c_last  = c_hart_w'(NUM_HARTS - 1);
  localparam logic [NUM_HARTS-1:0] c_one   = NUM_HARTS'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                r_state, w_nxt_state;
  logic [c_hart_w-1:0]   r_rr_ptr, w_nxt_ptr;
  logic [c_hart_w-1:0]   r_hart, w_nxt_hart;
  logic [c_cnt_w-1:0]    r_cnt, w_nxt_cnt;
  logic [ADDR_WIDTH-1:0] w_nxt_paddr;
  logic [DATA_WIDTH-1:0] w_nxt_pwdata, w_nxt_rdata;
  logic                  w_nxt_psel, w_nxt_penable, w_nxt_pwrite, w_nxt_err;
  logic [NUM_HARTS-1:0]  w_nxt_resp_valid;

  logic [ADDR_WIDTH-1:0] w_addr  [NUM_HARTS];
  logic [DATA_WIDTH-1:0] w_wdata [NUM_HARTS];
  logic [c_hart_w-1:0]   w_gnt, w_gnt_hi, w_gnt_lo;
  logic                  w_found_hi, w_timeout;

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_unpack
    assign w_addr[h]  = req_addr[h*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[h] = req_wdata[h*DATA_WIDTH +: DATA_WIDTH];
  end

  // Lowest requester at/above rr_ptr wins; otherwise wrap to the lowest overall.
  always_comb begin
    w_found_hi = 1'b0;
    w_gnt_hi   = '0;
    w_gnt_lo   = '0;
    for (int h = NUM_HARTS - 1; h >= 0; h--) begin
      if (req_valid[h]) w_gnt_lo = c_hart_w'(h);
      if (req_valid[h] && (c_hart_w'(h) >= r_rr_ptr)) begin
        w_found_hi = 1'b1;
        w_gnt_hi   = c_hart_w'(h);
      end
    end
    w_gnt = w_found_hi ? w_gnt_hi : w_gnt_lo;
  end

  assign req_ready = (rst_n && (r_state == S_IDLE) && (|req_valid)) ? (c_one << w_gnt) : '0;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_limit);

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_ptr        = r_rr_ptr;
    w_nxt_hart       = r_hart;
    w_nxt_cnt        = r_cnt;
    w_nxt_paddr      = paddr;
    w_nxt_pwrite     = pwrite;
    w_nxt_pwdata     = pwdata;
    w_nxt_psel       = psel;
    w_nxt_penable    = penable;
    w_nxt_resp_valid = '0;
    w_nxt_rdata      = '0;
    w_nxt_err        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_nxt_state   = S_SETUP;
          w_nxt_hart    = w_gnt;
          w_nxt_paddr   = w_addr[w_gnt];
          w_nxt_pwrite  = req_write[w_gnt];
          w_nxt_pwdata  = w_wdata[w_gnt];
          w_nxt_ptr     = (w_gnt == c_last) ? '0 : w_gnt + 1'b1;
          w_nxt_psel    = 1'b1;
          w_nxt_penable = 1'b0;
        end
      end
      S_SETUP: begin
        w_nxt_state   = S_ACCESS;
        w_nxt_penable = 1'b1;
        w_nxt_cnt     = '0;
      end
      S_ACCESS: begin
        // pready wins over a watchdog hit in the same cycle.
        if (pready) begin
          w_nxt_state      = S_IDLE;
          w_nxt_psel       = 1'b0;
          w_nxt_penable    = 1'b0;
          w_nxt_resp_valid = c_one << r_hart;
          w_nxt_rdata      = pwrite ? '0 : prdata;
          w_nxt_err        = pslverr;
        end else if (w_timeout) begin
          w_nxt_state      = S_IDLE;
          w_nxt_psel       = 1'b0;
          w_nxt_penable    = 1'b0;
          w_nxt_resp_valid = c_one << r_hart;
          w_nxt_err        = 1'b1;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nxt_state   = S_IDLE;
        w_nxt_psel    = 1'b0;
        w_nxt_penable = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_hart     <= '0;
      r_cnt      <= '0;
      paddr      <= '0;
      pwrite     <= 1'b0;
      pwdata     <= '0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      resp_valid <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_rr_ptr   <= w_nxt_ptr;
      r_hart     <= w_nxt_hart;
      r_cnt      <= w_nxt_cnt;
      paddr      <= w_nxt_paddr;
      pwrite     <= w_nxt_pwrite;
      pwdata     <= w_nxt_pwdata;
      psel       <= w_nxt_psel;
      penable    <= w_nxt_penable;
      resp_valid <= w_nxt_resp_valid;
      resp_rdata <= w_nxt_rdata;
      resp_err   <= w_nxt_err;
    end
  end

endmodule
`default_nettype wire

// File: doc/pito_apb_arbiter.md
# pito_apb_arbiter

Round-robin arbiter that shares the SoC's single APB master port, which reaches the MVU CSR space, among the pito barrel-processor harts. Each hart posts one read or write request. The block grants one request at a time and runs a standard two-phase APB transfer. It then returns read data, error status and completion to the granting hart. A per-transfer watchdog aborts transfers to a hung slave so one stalled hart cannot block the others.

## Interface
Parameters:
- NUM_HARTS, 8, number of requesters; at least 2.
- ADDR_WIDTH, 32, APB address width (matches pito_pkg::APB_ADDR_WIDTH).
- DATA_WIDTH, 32, APB data width (matches pito_pkg::APB_DATA_WIDTH).
- TIMEOUT_CYCLES, 1024, maximum ACCESS-phase cycles before abort; 0 disables the watchdog.

Ports:
- clk, in, 1, single clock; all state on its rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, NUM_HARTS, per-hart request; held with its fields until that hart's req_ready.
- req_write, in, NUM_HARTS, 1 = write, 0 = read.
- req_addr, in, NUM_HARTS*ADDR_WIDTH, hart h in slice [h*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata, in, NUM_HARTS*DATA_WIDTH, same slicing as req_addr.
- req_ready, out, NUM_HARTS, one-hot single-cycle acceptance pulse.
- resp_valid, out, NUM_HARTS, one-hot single-cycle completion pulse.
- resp_rdata, out, DATA_WIDTH, read data; valid while any resp_valid bit is high.
- resp_err, out, 1, pslverr or timeout; valid while any resp_valid bit is high.
- paddr, out, ADDR_WIDTH, APB address.
- psel, out, 1, APB select.
- penable, out, 1, APB enable.
- pwrite, out, 1, APB write.
- pwdata, out, DATA_WIDTH, APB write data.
- prdata, in, DATA_WIDTH, APB read data.
- pready, in, 1, APB ready.
- pslverr, in, 1, APB slave error.

## Operation
- State machine:
  - IDLE: if any req_valid, grant hart g and enter SETUP.
  - SETUP: drive psel=1, penable=0; always enter ACCESS.
  - ACCESS: drive psel=1, penable=1. Complete on pready, or abort on timeout; either way return to IDLE.
- Grant selection:
  - g is the first asserted req_valid at or after rr_ptr, searching upward modulo NUM_HARTS.
  - req_ready[g] pulses for the IDLE cycle.
  - On that edge, register g, req_write, req_addr and req_wdata into paddr, pwrite, pwdata and the stored hart id; set rr_ptr = (g+1) mod NUM_HARTS.
- APB drive: paddr, pwrite and pwdata stay constant from SETUP through the end of ACCESS.
- Normal completion (pready=1 in ACCESS):
  - On the next edge, pulse resp_valid[hart] for 1 cycle.
  - resp_rdata = prdata for a read, 0 for a write; resp_err = pslverr.
- Watchdog abort:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT_CYCLES, drop psel/penable on the next edge and pulse resp_valid with resp_err=1, resp_rdata=0.
  - The watchdog never fires when TIMEOUT_CYCLES=0.
- Simultaneous events:
  - pready arriving in the same cycle the counter hits its limit counts as normal completion.
  - Requests arriving while busy wait; req_ready stays 0 outside IDLE.
- A hart dropping req_valid before acceptance is illegal; the behaviour is undefined.

## Timing
- Reset (asynchronous, immediate): all outputs 0, rr_ptr=0, state IDLE, counter 0.
- A reset mid-transfer drops psel/penable at once, and no resp_valid is issued.
- Request accepted in cycle T (IDLE): SETUP in T+1, ACCESS in T+2.
- Zero-wait slave: pready in T+2, resp_valid in T+3, state IDLE in T+3.
- Minimum throughput: one transfer per 3 cycles. The IDLE cycle that issues resp_valid may accept the next request, so req_ready and resp_valid can be high together, for different or the same hart.
- Each wait state adds one cycle.
- Timeout: with no pready, resp_valid (err) arrives at T+3+TIMEOUT_CYCLES.
- All outputs are registered except req_ready, which is combinational from req_valid, rr_ptr and state.

## Test plan
- Single write from hart 3 (addr 0x20, data 0xDEAD_BEEF), pready tied 1 -> req_ready[3] at T; psel at T+1 (penable=0); penable at T+2; resp_valid[3] at T+3 with resp_err=0, resp_rdata=0.
- All 8 harts request at once after reset -> grant order 0,1,…,7; grants spaced 3 cycles apart; each resp_valid matches its hart; rr_ptr wraps to 0.
- Read from hart 5, prdata=0x1234_5678, pready low for 4 ACCESS cycles -> resp_valid[5] at T+7 with rdata 0x1234_5678; paddr, psel and pwrite stable throughout.
- pslverr=1 with pready on a hart 2 write -> resp_valid[2] with resp_err=1; the next request is granted in the same cycle.
- TIMEOUT_CYCLES=16, pready held 0 on a hart 1 read -> psel drops and resp_valid[1] pulses with err=1, rdata=0 at T+19; hart 4's pending request is then served normally.
- rst_n asserted during ACCESS -> psel, penable, resp_valid and req_ready go to 0 immediately. After release, the first grant goes to the lowest requesting hart (rr_ptr=0).
